// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//
// Turns one raw, bouncy, asynchronous push-button line into a clean,
// synchronous, active-high level. The input first passes through a 2-flop
// synchronizer. A four-state qualification FSM then accepts a level change
// only after STABLE_CYCLES consecutive identical synchronized samples.
//
// key_level feeds a one-shot press detector, so it must never glitch. It may
// only toggle after a fully qualified change. An opposite sample seen during
// qualification throws the candidate away and returns the FSM to the stable
// state.
//
// Parameters:
//   STABLE_CYCLES : consecutive identical samples needed to accept a change
//                   (legal range 2 .. 2**24; 50000 = 1 ms at 50 MHz)
//   ACTIVE_LOW_IN : 1 -> key_raw==0 means pressed, 0 -> key_raw==1 means pressed
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset; release is taken on a clk edge
//   key_raw   in   raw button pin, asynchronous to clk
//   key_level out  debounced level, 1 = pressed (registered)
//   busy      out  1 while a candidate level change is being qualified (registered)
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter bit          ACTIVE_LOW_IN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic busy
);

    // Wide enough to hold STABLE_CYCLES itself. The counter never goes
    // above STABLE_CYCLES-1, so it can never wrap.
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Input normalisation and synchronizer
    // -----------------------------------------------------------------------
    // Polarity is folded in before the synchronizer. Everything downstream
    // then sees 1 = pressed, whatever the board wiring.
    logic p;
    logic sync1;
    logic s;

    assign p = key_raw ^ ACTIVE_LOW_IN;

    // NOTE: every clocked block uses non-blocking assignments (<=). All
    // flops then update together from pre-edge values. This is what makes
    // s trail sync1 by exactly one cycle.
    // NOTE: the reset is asynchronous, so it acts without waiting for a clock
    // edge. Only control state is reset here; this block holds no memories.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= p;
            s     <= sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Qualification FSM: state register
    // -----------------------------------------------------------------------
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;
    logic             busy_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RELEASED;
            cnt       <= '0;
            key_level <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            key_level <= level_next;
            busy      <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // Qualification FSM: next state, counter and output decode
    // -----------------------------------------------------------------------
    // cnt holds how many consecutive candidate samples have been seen so far.
    // The sample that starts qualification counts as 1. The change is
    // accepted on the edge that sees sample number STABLE_CYCLES.
    always_comb begin
        // NOTE: defaults are assigned before the case statement. Every path
        // then drives every signal, so no latch can be inferred. These
        // defaults also send any unexpected encoding back to RELEASED.
        state_next = RELEASED;
        cnt_next   = '0;

        case (state)
            RELEASED: begin
                if (s) begin
                    state_next = CHK_PRESS;
                    cnt_next   = ONE_CNT;
                end else begin
                    state_next = RELEASED;
                end
            end

            CHK_PRESS: begin
                if (!s) begin
                    state_next = RELEASED;           // bounce: discard candidate
                end else if (cnt == LAST_CNT) begin
                    state_next = PRESSED;            // press qualified
                end else begin
                    state_next = CHK_PRESS;
                    cnt_next   = cnt + ONE_CNT;
                end
            end

            PRESSED: begin
                if (!s) begin
                    state_next = CHK_REL;
                    cnt_next   = ONE_CNT;
                end else begin
                    state_next = PRESSED;
                end
            end

            CHK_REL: begin
                if (s) begin
                    state_next = PRESSED;            // bounce: discard candidate
                end else if (cnt == LAST_CNT) begin
                    state_next = RELEASED;           // release qualified
                end else begin
                    state_next = CHK_REL;
                    cnt_next   = cnt + ONE_CNT;
                end
            end

            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase

        // Outputs are decoded from the next state and then registered, so
        // they line up with the state register and have no path back to
        // key_raw. key_level stays high through CHK_REL; it only drops once
        // the release has been qualified.
        level_next = (state_next == PRESSED)   || (state_next == CHK_REL);
        busy_next  = (state_next == CHK_PRESS) || (state_next == CHK_REL);
    end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one raw push-button line (DE1-SoC KEY, asynchronous, mechanically bouncy) into a clean, synchronous, active-high level.
- Sits directly upstream of the one-shot press detector: key_level drives that stage's `in` and is guaranteed glitch-free, so each physical press yields exactly one downstream pulse.
- Structure: 2-flop synchronizer, then a 4-state qualification FSM with a consecutive-sample counter.

Parameters:
- STABLE_CYCLES, 50000, consecutive identical synchronized samples required to accept a level change (1 ms at 50 MHz). Legal range: 2 to 2^24.
- ACTIVE_LOW_IN, 1, 1: key_raw==0 means pressed (DE1-SoC KEYs). 0: key_raw==1 means pressed.
- CNT_W is a localparam, $clog2(STABLE_CYCLES+1). It is not user-set.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset. Asserted when 0; asserts asynchronously and releases on a clk edge.
- key_raw  input  1  raw button pin, asynchronous to clk.
- key_level  output  1  debounced level, 1 = pressed. Registered.
- busy  output  1  1 while a candidate level change is being qualified (state CHK_PRESS or CHK_REL). Registered.

Behaviour:
- Normalisation: p = key_raw XOR ACTIVE_LOW_IN, so p=1 means pressed. This is applied before the synchronizer.
- Synchronizer: sync1 <= p; s <= sync1. Only s is used downstream of the synchronizer; key_raw never reaches the FSM directly.
- Reset (reset==0): state=RELEASED, cnt=0, sync1=0, s=0, key_level=0, busy=0.
  - Reset asserted mid-qualification discards the partial count.
  - Reset asserted while PRESSED forces key_level=0 immediately (asynchronous).
- States: RELEASED, CHK_PRESS, PRESSED, CHK_REL.
- RELEASED:
  - s=1: go to CHK_PRESS, cnt<=1.
  - Otherwise: stay, cnt<=0.
- CHK_PRESS:
  - s=0: bounce, return to RELEASED, cnt<=0.
  - s=1 and cnt==STABLE_CYCLES-1: go to PRESSED, cnt<=0.
  - s=1 otherwise: cnt<=cnt+1.
- PRESSED:
  - s=0: go to CHK_REL, cnt<=1.
  - Otherwise: stay.
- CHK_REL:
  - s=1: bounce, return to PRESSED, cnt<=0.
  - s=0 and cnt==STABLE_CYCLES-1: go to RELEASED, cnt<=0.
  - s=0 otherwise: cnt<=cnt+1.
- Outputs are registered, computed from the next state:
  - key_level = 1 in PRESSED or CHK_REL. It does not drop until release is qualified.
  - busy = 1 in CHK_PRESS or CHK_REL.
- Latency:
  - Take E0 as the first clk edge that samples the new stable p.
  - s changes at E1; the FSM first sees it at E2.
  - key_level changes at edge E(STABLE_CYCLES+1).
  - Total STABLE_CYCLES+2 edges after the input becomes stable. The same figure applies to press and release.
- Any opposite sample during qualification restarts qualification from the stable state. A bounce therefore never produces a key_level toggle.
- Counter never exceeds STABLE_CYCLES-1 and never wraps; CNT_W covers the full range.
- Pulses on p shorter than STABLE_CYCLES samples are always rejected. A pulse of exactly STABLE_CYCLES samples is accepted.
- Unused/illegal state encodings go to RELEASED on the next edge.
- No combinational path from key_raw to any output.

Test Plan:
All scenarios use STABLE_CYCLES=4, ACTIVE_LOW_IN=1, clk period 100.
1. Reset low for 2 cycles with key_raw=1, then release -> key_level=0, busy=0; key_level stays 0 for 20 cycles of key_raw=1.
2. Clean press: key_raw 1->0 just before edge E0 and held -> busy=1 after E2, key_level=1 after E5, busy=0 after E5. Then key_raw 0->1 held -> key_level=0 exactly 6 edges later.
3. Bounce reject: key_raw low for 3 cycles, high 1 cycle, low 2 cycles, then high -> key_level never 1; busy pulses and then returns to 0.
4. Bounce then settle: key_raw toggles every cycle for 5 cycles, then held 0 -> key_level=1 exactly 6 edges after the final falling transition's first sampling edge; exactly one 0->1 transition on key_level.
5. Reset mid-press: key_level=1, then reset=0 asynchronously between edges -> key_level=0 before the next edge. After reset release with key_raw still 0 -> key_level=1 again after 6 edges.
6. ACTIVE_LOW_IN=0 instance: key_raw 0->1 held -> key_level=1 after 6 edges. A 1-cycle key_raw glitch of 1 -> no change.
